// File: rtl/ber_pkg.sv
// ber_pkg: shared FSM encoding, default thresholds and saturating add for the QPSK BER checker
package ber_pkg;
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int DEF_WIN_LEN    = 256;
    localparam int DEF_LOCK_THR   = 4;
    localparam int DEF_UNLOCK_THR = 64;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_v;
        logic [63:0] sum;
        max_v = (64'd1 << w) - 64'd1;
        sum   = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction
endpackage

// File: rtl/ref_delay_line.sv
// ref_delay_line: valid-qualified shift register of {ref_I, ref_Q} pairs; tap 0 bypasses to the live input
module ref_delay_line #(
    parameter int MAX_DLY = 32,
    parameter int DLY_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [1:0]       din,
    input  logic [DLY_W-1:0] sel,
    output logic [1:0]       dout
);
    logic [1:0] sr_q [1:MAX_DLY-1];
    logic [1:0] sr_d [1:MAX_DLY-1];
    logic [1:0] taps [0:MAX_DLY-1];

    always_comb begin
        sr_d[1] = shift_en ? din : sr_q[1];
        for (int k = 2; k < MAX_DLY; k++) sr_d[k] = shift_en ? sr_q[k-1] : sr_q[k];
        taps[0] = din;
        for (int k = 1; k < MAX_DLY; k++) taps[k] = sr_q[k];
    end

    assign dout = taps[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < MAX_DLY; k++) sr_q[k] <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end
endmodule

// File: rtl/qpsk_ber_checker.sv
// qpsk_ber_checker: slices rx symbols, searches reference delay for lock, then accumulates bit/error counts
module qpsk_ber_checker
    import ber_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int MAX_DLY    = 32,
    parameter int DLY_W      = 5,
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int WERR_W     = 10,
    parameter int LOCK_THR   = DEF_LOCK_THR,
    parameter int UNLOCK_THR = DEF_UNLOCK_THR,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DWIDTH-1:0] rx_I,
    input  logic signed [DWIDTH-1:0] rx_Q,
    input  logic                     ref_I,
    input  logic                     ref_Q,
    input  logic                     clear,
    output logic                     locked,
    output logic [DLY_W-1:0]         lock_delay,
    output logic [CNT_W-1:0]         bit_count,
    output logic [CNT_W-1:0]         err_count
);
    // win_cnt doubles as the FILL symbol counter, so it must cover both ranges
    localparam int WC_W = $clog2(WIN_LEN > MAX_DLY ? WIN_LEN : MAX_DLY);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0] win_err_q, win_err_d, win_tot;
    logic [DLY_W-1:0]  dly_q, dly_d, dly_inc;
    logic [CNT_W-1:0]  bit_q, bit_d, err_q, err_d;
    logic [1:0]        tap;
    logic [1:0]        errs;
    logic              win_end, fill_end;

    ref_delay_line #(.MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) u_dly (
        .clk      (clk),
        .rst      (rst),
        .shift_en (valid_in),
        .din      ({ref_I, ref_Q}),
        .sel      (dly_q),
        .dout     (tap)
    );

    always_comb begin
        errs     = {1'b0, (rx_I < 0) != tap[1]} + {1'b0, (rx_Q < 0) != tap[0]};
        win_tot  = win_err_q + WERR_W'(errs);
        win_end  = win_cnt_q == WC_W'(WIN_LEN - 1);
        fill_end = win_cnt_q == WC_W'(MAX_DLY - 1);
        dly_inc  = (dly_q == DLY_W'(MAX_DLY - 1)) ? '0 : dly_q + DLY_W'(1);
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        dly_d     = dly_q;
        bit_d     = bit_q;
        err_d     = err_q;
        if (valid_in && state_q == FILL) begin
            win_cnt_d = fill_end ? '0 : win_cnt_q + WC_W'(1);
            state_d   = fill_end ? SEARCH : FILL;
            dly_d     = '0;
        end else if (valid_in) begin
            win_cnt_d = win_end ? '0 : win_cnt_q + WC_W'(1);
            win_err_d = win_end ? '0 : win_tot;
            if (state_q == LOCKED) begin
                bit_d = CNT_W'(sat_add(64'(bit_q), 64'd2, CNT_W));
                err_d = CNT_W'(sat_add(64'(err_q), 64'(errs), CNT_W));
            end
            if (win_end && state_q == SEARCH) begin
                state_d = (win_tot <= WERR_W'(LOCK_THR)) ? LOCKED : SEARCH;
                dly_d   = (win_tot <= WERR_W'(LOCK_THR)) ? dly_q : dly_inc;
            end
            if (win_end && state_q == LOCKED && win_tot > WERR_W'(UNLOCK_THR)) begin
                state_d = SEARCH;
                dly_d   = dly_inc;
            end
        end
        bit_d = clear ? '0 : bit_d;
        err_d = clear ? '0 : err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            win_cnt_q <= '0;
            win_err_q <= '0;
            dly_q     <= '0;
            bit_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            dly_q     <= dly_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
        end
    end

    assign locked     = state_q == LOCKED;
    assign lock_delay = dly_q;
    assign bit_count  = bit_q;
    assign err_count  = err_q;
endmodule

// File: tb/tb_qpsk_ber_checker.sv
// tb_qpsk_ber_checker: random-stimulus bench with a queue-based reference model, 32-bit and 8-bit counter instances
module tb_qpsk_ber_checker;
    localparam int MD = 32;
    localparam int WL = 256;
    localparam int CH_DLY = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic clear = 1'b0;
    logic ref_I = 1'b0;
    logic ref_Q = 1'b0;
    logic signed [15:0] rx_I = '0;
    logic signed [15:0] rx_Q = '0;

    logic        locked_a, locked_b;
    logic [4:0]  dly_a, dly_b;
    logic [31:0] bits_a, errs_a;
    logic [7:0]  bits_b, errs_b;

    always #5 clk = ~clk;

    qpsk_ber_checker dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rx_I(rx_I), .rx_Q(rx_Q),
        .ref_I(ref_I), .ref_Q(ref_Q), .clear(clear), .locked(locked_a),
        .lock_delay(dly_a), .bit_count(bits_a), .err_count(errs_a)
    );

    qpsk_ber_checker #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rx_I(rx_I), .rx_Q(rx_Q),
        .ref_I(ref_I), .ref_Q(ref_Q), .clear(clear), .locked(locked_b),
        .lock_delay(dly_b), .bit_count(bits_b), .err_count(errs_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model: phase 0 fill, 1 search, 2 locked; counts are unbounded and clamped when compared
    logic [1:0] mhist[$];
    int mstate, mnum, mwerr, mdly;
    longint mbits, merrs;

    logic [1:0] txh[$];
    int ph_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] samp(input logic b);
        int v;
        v = int'($urandom_range(0, 300));
        return b ? 16'(-(v + 1)) : 16'(v);
    endfunction

    function automatic longint clamp(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        mhist.delete();
        mstate = 0; mnum = 0; mwerr = 0; mdly = 0; mbits = 0; merrs = 0;
    endtask

    task automatic model_step();
        logic [1:0] cur, t;
        int e;
        if (valid_in) begin
            cur = {ref_I, ref_Q};
            t = (mdly == 0) ? cur : (mhist.size() >= mdly ? mhist[mhist.size() - mdly] : 2'b00);
            e = int'((rx_I < 0) != t[1]) + int'((rx_Q < 0) != t[0]);
            mhist.push_back(cur);
            if (mhist.size() > MD) void'(mhist.pop_front());
            if (mstate == 0) begin
                mnum++;
                if (mnum == MD) begin mstate = 1; mnum = 0; end
            end else begin
                if (mstate == 2) begin mbits += 2; merrs += e; end
                mwerr += e;
                mnum++;
                if (mnum == WL) begin
                    if (mstate == 1) begin
                        if (mwerr <= 4) mstate = 2;
                        else mdly = (mdly + 1) % MD;
                    end else if (mwerr > 64) begin
                        mstate = 1;
                        mdly = (mdly + 1) % MD;
                    end
                    mnum = 0; mwerr = 0;
                end
            end
        end
        if (clear) begin mbits = 0; merrs = 0; end
    endtask

    task automatic check_all();
        chk("locked", 64'(locked_a), 64'(mstate == 2));
        chk("lock_delay", 64'(dly_a), 64'(mdly));
        chk("bit_count", 64'(bits_a), 64'(clamp(mbits, 64'hFFFF_FFFF)));
        chk("err_count", 64'(errs_a), 64'(clamp(merrs, 64'hFFFF_FFFF)));
        chk("locked_w8", 64'(locked_b), 64'(mstate == 2));
        chk("lock_delay_w8", 64'(dly_b), 64'(mdly));
        chk("bit_count_w8", 64'(bits_b), 64'(clamp(mbits, 255)));
        chk("err_count_w8", 64'(errs_b), 64'(clamp(merrs, 255)));
    endtask

    // mode 0 clean delayed channel, 1 invert I every 100th, 3 invert I every 8th, 2 unrelated data
    task automatic cyc(input logic v, input logic c, input int mode);
        logic [1:0] p;
        logic inv;
        valid_in = v;
        clear = c;
        {ref_I, ref_Q} = 2'($urandom);
        if (v) begin
            txh.push_back({ref_I, ref_Q});
            if (txh.size() > 64) void'(txh.pop_front());
            p = (txh.size() > CH_DLY) ? txh[txh.size() - 1 - CH_DLY] : 2'b00;
            ph_cnt++;
            inv = (mode == 1 && ph_cnt % 100 == 0) || (mode == 3 && ph_cnt % 8 == 0);
            if (mode == 2) p = 2'($urandom);
            rx_I = samp(p[1] ^ inv);
            rx_Q = samp(p[0]);
        end else begin
            rx_I = 16'($urandom);
            rx_Q = 16'($urandom);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic sym(input int mode);
        while ($urandom_range(0, 7) == 0) cyc(1'b0, 1'b0, mode);
        cyc(1'b1, 1'b0, mode);
    endtask

    task automatic run_lock();
        for (int i = 1; i < 32 + 16 * WL; i++) sym(0);
        chk("prelock_low", 64'(locked_a), 64'd0);
        sym(0);
        chk("lock_rise", 64'(locked_a), 64'd1);
        chk("lock_dly15", 64'(dly_a), 64'd15);
        chk("lock_err0", 64'(errs_a), 64'd0);
        chk("lock_bits0", 64'(bits_a), 64'd0);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_locked", 64'(locked_a), 64'd0);
        chk("rst_bits", 64'(bits_a), 64'd0);
        chk("rst_dly", 64'(dly_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_lock();

        ph_cnt = 0;
        repeat (10000) sym(1);
        chk("sparse_err", 64'(errs_a), 64'd100);
        chk("sparse_bits", 64'(bits_a), 64'd20000);
        chk("sparse_locked", 64'(locked_a), 64'd1);
        chk("w8_bits_sat", 64'(bits_b), 64'd255);

        ph_cnt = 0;
        repeat (2560) sym(3);
        chk("dense_err", 64'(errs_a), 64'd420);
        chk("dense_bits", 64'(bits_a), 64'd25120);
        chk("w8_err_sat", 64'(errs_b), 64'd255);
        chk("dense_locked", 64'(locked_a), 64'd1);

        cyc(1'b1, 1'b1, 0);
        chk("clear_bits", 64'(bits_a), 64'd0);
        chk("clear_err", 64'(errs_a), 64'd0);
        chk("clear_bits_w8", 64'(bits_b), 64'd0);
        sym(0);
        chk("post_clear_bits", 64'(bits_a), 64'd2);
        chk("post_clear_locked", 64'(locked_a), 64'd1);
        chk("post_clear_dly", 64'(dly_a), 64'd15);

        repeat (100) sym(0);
        #2 rst = 1'b1;
        #1;
        chk("arst_locked", 64'(locked_a), 64'd0);
        chk("arst_dly", 64'(dly_a), 64'd0);
        chk("arst_bits", 64'(bits_a), 64'd0);
        chk("arst_err", 64'(errs_a), 64'd0);
        chk("arst_bits_w8", 64'(bits_b), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_lock();

        begin
            int k;
            k = 0;
            while (locked_a && k < 1500) begin
                sym(2);
                k++;
            end
        end
        chk("unlock", 64'(locked_a), 64'd0);
        chk("unlock_dly16", 64'(dly_a), 64'd16);
        repeat (50) sym(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
